// File: rtl/cdb_result_queue.sv
// rtl/cdb_result_queue.sv - in-order result buffer between one execution unit and the CDB arbiter
// Head entry is presented on a ready/ack interface until the arbiter grants a CDB slot.
module cdb_result_queue #(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1),
  parameter int ROB_WIDTH = 6,
  parameter int EX_WIDTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [ROB_WIDTH-1:0] i_in_reorder,
  input  logic [31:0]          i_in_data,
  input  logic [EX_WIDTH-1:0]  i_in_ex,
  output logic                 o_data_ready,
  output logic [ROB_WIDTH-1:0] o_data_reorder,
  output logic [31:0]          o_data,
  output logic [EX_WIDTH-1:0]  o_ex,
  input  logic                 i_data_ack,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [ROB_WIDTH-1:0] r_reorder_mem [DEPTH];
  logic [31:0]          r_data_mem    [DEPTH];
  logic [EX_WIDTH-1:0]  r_ex_mem      [DEPTH];

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_overflow;

  logic w_in_ready;
  logic w_data_ready;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Pointers wrap explicitly so non-power-of-2 depths stay correct.
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    f_next = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_in_ready   = (r_count < FULL_CNT);
  assign w_data_ready = (r_count != '0);
  assign w_push       = i_in_valid && w_in_ready && !i_flush;
  assign w_pop        = w_data_ready && i_data_ack;
  assign w_drop       = i_in_valid && !w_in_ready && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_reorder_mem[r_tail] <= i_in_reorder;
      r_data_mem[r_tail]    <= i_in_data;
      r_ex_mem[r_tail]      <= i_in_ex;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      // A flush also swallows any same-cycle push and pop.
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= f_next(r_tail);
        end
        if (w_pop) begin
          r_head <= f_next(r_head);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_WIDTH'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_data_ready   = w_data_ready;
  assign o_data_reorder = w_data_ready ? r_reorder_mem[r_head] : '0;
  assign o_data         = w_data_ready ? r_data_mem[r_head]    : '0;
  assign o_ex           = w_data_ready ? r_ex_mem[r_head]      : '0;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_cdb_result_queue.sv
// tb/tb_cdb_result_queue.sv - directed scoreboard bench for cdb_result_queue
// A reference model tracks occupancy and the expected in-order result stream.
module tb_cdb_result_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_reorder;
  logic [31:0] in_data;
  logic [3:0]  in_ex;
  logic        data_ready;
  logic [5:0]  data_reorder;
  logic [31:0] data;
  logic [3:0]  ex;
  logic        data_ack;
  logic [CW-1:0] count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [41:0] sb[$];
  int          m_count = 0;
  logic        m_ovf   = 1'b0;

  cdb_result_queue #(.DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_reorder   (in_reorder),
    .i_in_data      (in_data),
    .i_in_ex        (in_ex),
    .o_data_ready   (data_ready),
    .o_data_reorder (data_reorder),
    .o_data         (data),
    .o_ex           (ex),
    .i_data_ack     (data_ack),
    .o_count        (count),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, then advance model and DUT by one edge.
  task automatic tick();
    logic [41:0] head;
    logic        pop;
    logic        push;
    #1;
    chk("data_ready", 64'(data_ready), 64'(m_count != 0));
    chk("in_ready",   64'(in_ready),   64'(m_count < DEPTH));
    chk("count",      64'(count),      64'(m_count));
    chk("overflow",   64'(overflow),   64'(m_ovf));
    head = (m_count != 0) ? sb[0] : 42'd0;
    chk("head_payload", 64'({data_reorder, data, ex}), 64'(head));
    pop  = (m_count != 0) && data_ack;
    push = in_valid && (m_count < DEPTH) && !flush;
    if (in_valid && (m_count == DEPTH) && !flush) m_ovf = 1'b1;
    if (flush) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back({in_reorder, in_data, in_ex});
    end
    m_count = sb.size();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [5:0] tag, input logic a);
    in_valid   = v;
    in_reorder = tag;
    in_data    = $urandom;
    in_ex      = 4'($urandom_range(0, 15));
    data_ack   = a;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 6'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset then idle
    tick();
    tick();

    // latency: push tag 5 with ack held
    drive(1'b1, 6'd5, 1'b1);
    in_data = 32'hDEADBEEF; in_ex = 4'd0;
    tick();
    drive(1'b0, 6'd0, 1'b1);
    chk("lat_tag", 64'(data_reorder), 64'd5);
    chk("lat_data", 64'(data), 64'hDEADBEEF);
    tick();
    tick();

    // fill, backpressure, dropped push sets sticky overflow
    drive(1'b1, 6'd1, 1'b0); tick();
    drive(1'b1, 6'd2, 1'b0); tick();
    drive(1'b1, 6'd3, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    tick();
    tick();
    drive(1'b0, 6'd0, 1'b0); tick();

    // simultaneous push/pop across pointer wrap
    drive(1'b1, 6'd9, 1'b0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 6'(10 + i), 1'b1);
      tick();
    end
    drive(1'b0, 6'd0, 1'b1); tick();
    drive(1'b0, 6'd0, 1'b0); tick();

    // flush with full queue, concurrent push and ack
    drive(1'b1, 6'd20, 1'b0); tick();
    drive(1'b1, 6'd21, 1'b0); tick();
    drive(1'b1, 6'd33, 1'b1); flush = 1'b1; tick();
    flush = 1'b0;
    drive(1'b0, 6'd0, 1'b0); tick();
    tick();

    // async reset mid-stream
    drive(1'b1, 6'd40, 1'b0); tick();
    drive(1'b1, 6'd41, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    sb.delete(); m_count = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    drive(1'b1, 6'd42, 1'b0); tick();
    drive(1'b0, 6'd0, 1'b1); tick();
    drive(1'b0, 6'd0, 1'b0); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_result_queue.md
Name: cdb_result_queue

Overview:
- Producer-side result buffer between one execution unit and the CDB arbitrator.
- Accepts completed results (ROB tag, value, exception) from the unit, holds them in order, and presents the head entry on a ready/ack interface.
- Presented results stay on the interface until the arbitrator grants a CDB slot.
- Decouples unit completion from CDB grant so the unit never stalls on a lost arbitration unless the queue is full.

Parameters:
- DEPTH, 2, number of result entries (≥1; need not be a power of 2).
- CNT_WIDTH, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  pipeline flush; discard all held and incoming results.
- in_valid  input  1  unit presents a completed result this cycle.
- in_ready  output  1  queue can accept a result this cycle.
- in_reorder  input  rob_index_t  ROB index of incoming result.
- in_data  input  uint32_t  result value.
- in_ex  input  exception_t  exception info of incoming result.
- data_ready  output  1  head entry valid, requesting CDB.
- data_reorder  output  rob_index_t  head ROB index.
- data  output  uint32_t  head value.
- ex  output  exception_t  head exception info.
- data_ack  input  1  arbitrator grant; head broadcast on CDB this cycle.
- count  output  CNT_WIDTH  current occupancy.
- overflow  output  1  sticky error: push attempted while full.

Behaviour:
- Clocking and reset: one clock domain. rst asynchronous, active-high.
- Reset values: head=0, tail=0, count=0, overflow=0. Hence data_ready=0, in_ready=1, and data_reorder/data/ex all '0.
- Storage: circular buffer of DEPTH entries {reorder, data, ex}. head/tail wrap explicitly from DEPTH-1 to 0 (no modulo-2^n assumption).
- Outputs:
  - data_ready = (count != 0).
  - Head payload is driven combinationally from storage[head].
  - Payload outputs are '0 when count==0 (deterministic, no stale data).
- in_ready = (count < DEPTH). It is a function of registered state only: no combinational path from data_ack or in_valid.
- Push: in_valid && in_ready && !flush. Writes storage[tail] and advances tail at the next edge.
- Pop: data_ready && data_ack. Advances head at the next edge. data_ack while data_ready=0 is ignored.
- Latency: a pushed result appears on data_ready at the first edge after the push. There is no same-cycle bypass.
- Ordering: strict FIFO. Results are presented in push order.
- Simultaneous push and pop: both take effect and count is unchanged. This is legal at any count < DEPTH. At count==DEPTH, in_ready=0, so no push occurs even if a pop does.
- Illegal push: in_valid && !in_ready (and !flush) drops the result and sets overflow=1 at the next edge. overflow clears only on rst.
- Flush:
  - At the next edge, head=tail=0 and count=0. Any same-cycle push is discarded.
  - A same-cycle data_ack is a valid handshake toward the arbitrator (the CDB broadcast occurs), but the entry is discarded along with the rest.
  - flush does not affect overflow.
- Wrap-around: pointers wrap independently. Correct order must be preserved across the wrap with count at 0, 1, DEPTH-1, and DEPTH.
- Reset mid-operation: all entries are lost immediately (async). data_ready drops in the same cycle rst asserts.

Test Plan:
1. Reset then idle → data_ready=0, in_ready=1, count=0, overflow=0, payload=0.
2. Latency: push {reorder=5, data=0xDEADBEEF, ex=0} in cycle 0, data_ack=1 held → data_ready=1 with those values in cycle 1, count=0 and data_ready=0 in cycle 2.
3. Fill and backpressure: DEPTH=2, push tags 1 and 2 with ack=0 → count=2, in_ready=0. Then push tag 3 → dropped, overflow=1 (sticky). Then ack twice → tags 1 then 2 presented, tag 3 never appears.
4. Simultaneous push/pop and wrap: count=1, then push and ack together for 6 cycles with tags 10..15 → count stays 1, heads pop in order 9(pre-loaded),10,11,..., pointers wrap with no reordering.
5. Flush: count=2 plus in_valid and data_ack in the same cycle as flush → next cycle count=0, data_ready=0, incoming result absent, overflow unchanged.
6. Async reset mid-stream: assert rst between edges with count=2 → data_ready=0 immediately. After release, in_ready=1 and count=0.
